// File: rtl/cnn_pkg.sv
// Shared types and constants for the 3D pooling / unpooling datapath.
package cnn_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [2:0]                 idx_t;

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    DONE
  } unpool_state_t;

  // Bit positions of the per-axis offsets inside an argmax index {dz,dy,dx}.
  localparam int IDX_DZ = 2;
  localparam int IDX_DY = 1;
  localparam int IDX_DX = 0;

  // Packs per-axis window offsets into an argmax index.
  function automatic idx_t make_idx(input logic dz, input logic dy, input logic dx);
    idx_t r;
    r         = '0;
    r[IDX_DZ] = dz;
    r[IDX_DY] = dy;
    r[IDX_DX] = dx;
    return r;
  endfunction

endpackage

// File: rtl/cnn_3d_max_unpooling_if.sv
// Pooled-input / unpooled-output stream bundle of the unpooling block.
interface cnn_3d_max_unpooling_if #(
  parameter int DATA_W = 16
) ();
  import cnn_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  idx_t                     in_idx;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;
  logic                     done;

  // Stream source / sink side (testbench or neighbouring stages).
  modport master (
    output in_valid, in_data, in_idx, out_ready,
    input  in_ready, out_valid, out_data, out_last, done
  );

  // Unpooling block side.
  modport slave (
    input  in_valid, in_data, in_idx, out_ready,
    output in_ready, out_valid, out_data, out_last, done
  );

endinterface

// File: rtl/cnn_unpool_buf.sv
// One-filter register file of pooled {value, argmax} pairs: one write port,
// combinational read, cleared by reset.
module cnn_unpool_buf
  import cnn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  idx_t              i_wr_idx,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output idx_t              o_rd_idx
);

  logic [DATA_W-1:0] r_mem_data [DEPTH];
  idx_t              r_mem_idx  [DEPTH];

  // Storage update: clear on reset, otherwise write the accepted pooled sample.
  // NOTE: the storage is cleared on reset so a partially filled volume never leaks
  // stale data into the next run; this keeps it in flops rather than a RAM macro.
  // NOTE: state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_idx[i]  <= '0;
      end
    end else if (i_wr_en) begin
      r_mem_data[i_wr_addr] <= i_wr_data;
      r_mem_idx[i_wr_addr]  <= i_wr_idx;
    end
  end

  assign o_rd_data = r_mem_data[i_rd_addr];
  assign o_rd_idx  = r_mem_idx[i_rd_addr];

endmodule

// File: rtl/cnn_3d_max_unpooling.sv
// Streaming 3D max-unpooling: buffers one filter's pooled volume, then emits the
// full-resolution cube in raster order with each value at its argmax position.
module cnn_3d_max_unpooling
  import cnn_pkg::*;
#(
  parameter int OUT_SIZE    = 4,
  parameter int NUM_FILTERS = 3,
  parameter int DATA_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  cnn_3d_max_unpooling_if.slave  bus
);

  localparam int P    = OUT_SIZE / 2;
  localparam int N_IN = P * P * P;
  localparam int AW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CW   = $clog2(OUT_SIZE);
  localparam int FW   = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(OUT_SIZE - 1);

  unpool_state_t            r_state;
  logic [AW-1:0]            r_in_cnt;
  logic [FW-1:0]            r_filt;
  logic [CW-1:0]            r_x, r_y, r_z;      // coordinate of the next sample to load
  logic                     r_out_valid;
  logic                     r_out_last;
  logic signed [DATA_W-1:0] r_out_data;
  logic                     r_done;

  logic                     w_accept;
  logic                     w_in_last;
  logic                     w_out_hs;
  logic                     w_load;
  logic                     w_at_end;
  logic [AW-1:0]            w_rd_addr;
  logic [DATA_W-1:0]        w_buf_data;
  idx_t                     w_buf_idx;
  logic                     w_bypass;
  logic [DATA_W-1:0]        w_entry_data;
  idx_t                     w_entry_idx;
  idx_t                     w_pos_idx;
  logic [DATA_W-1:0]        w_sel_data;

  // Accept only in FILL; reset forces in_ready low during the reset cycle itself.
  assign bus.in_ready = (r_state == FILL) && !reset;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_in_last    = (r_in_cnt == AW'(N_IN - 1));
  assign w_out_hs     = r_out_valid && bus.out_ready;

  // Load the output register on the final accept (first sample) or on every
  // non-final output handshake (next sample).
  assign w_load = ((r_state == FILL) && w_accept && w_in_last) ||
                  ((r_state == EMIT) && w_out_hs && !r_out_last);

  assign w_at_end = (r_x == C_LAST) && (r_y == C_LAST) && (r_z == C_LAST);

  // Pooled entry covering output (z,y,x) is (z>>1, y>>1, x>>1) in raster order.
  assign w_rd_addr = AW'(int'(r_z >> 1) * P * P + int'(r_y >> 1) * P + int'(r_x >> 1));

  cnn_unpool_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (N_IN),
    .AW     (AW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_in_cnt),
    .i_wr_data (bus.in_data),
    .i_wr_idx  (bus.in_idx),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_buf_data),
    .o_rd_idx  (w_buf_idx)
  );

  // The first output is read on the same edge the final entry is written; forward
  // the incoming sample when both hit the same entry (single-entry volumes).
  assign w_bypass     = w_accept && (r_in_cnt == w_rd_addr);
  assign w_entry_data = w_bypass ? bus.in_data : w_buf_data;
  assign w_entry_idx  = w_bypass ? bus.in_idx  : w_buf_idx;

  assign w_pos_idx  = make_idx(r_z[0], r_y[0], r_x[0]);
  assign w_sel_data = (w_entry_idx == w_pos_idx) ? w_entry_data : '0;

  // FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= FILL;
      r_in_cnt    <= '0;
      r_filt      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      unique case (r_state)
        FILL: begin
          if (w_accept) begin
            if (w_in_last) begin
              r_in_cnt <= '0;
              r_state  <= EMIT;
            end else begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
          end
        end
        EMIT: begin
          if (w_out_hs && r_out_last) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            if (r_filt == FW'(NUM_FILTERS - 1)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_filt  <= r_filt + 1'b1;
              r_state <= FILL;
            end
          end
        end
        DONE: begin
          r_done <= 1'b1;
        end
        default: r_state <= FILL;
      endcase

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_last  <= w_at_end;
        if (r_x == C_LAST) begin
          r_x <= '0;
          if (r_y == C_LAST) begin
            r_y <= '0;
            r_z <= (r_z == C_LAST) ? '0 : r_z + 1'b1;
          end else begin
            r_y <= r_y + 1'b1;
          end
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_cnn_3d_max_unpooling.sv
// Self-checking bench for cnn_3d_max_unpooling (OUT_SIZE=4, NUM_FILTERS=3).
module tb_cnn_3d_max_unpooling;
  import cnn_pkg::*;

  localparam int OUT_SIZE    = 4;
  localparam int NUM_FILTERS = 3;
  localparam int DATA_W      = 16;
  localparam int N_IN        = 8;
  localparam int N_OUT       = 64;
  localparam int N_TOT       = N_OUT * NUM_FILTERS;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  cnn_3d_max_unpooling_if #(.DATA_W(DATA_W)) bus ();

  cnn_3d_max_unpooling #(
    .OUT_SIZE    (OUT_SIZE),
    .NUM_FILTERS (NUM_FILTERS),
    .DATA_W      (DATA_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] vec_val [NUM_FILTERS][N_IN];
  logic [2:0]  vec_idx [NUM_FILTERS][N_IN];
  logic [15:0] exp_data [N_TOT];
  logic        exp_last [N_TOT];
  logic [15:0] got_data [N_TOT];
  logic        got_last [N_TOT];
  int          got_cnt;
  int          overlap_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference placement: output (z,y,x) takes pooled (z/2,y/2,x/2) if its argmax
  // points at (z%2,y%2,x%2), otherwise zero.
  function automatic logic [15:0] model(input int f, input int i);
    int z, y, x, p, pos;
    z   = i / 16;
    y   = (i / 4) % 4;
    x   = i % 4;
    p   = (z / 2) * 4 + (y / 2) * 2 + (x / 2);
    pos = (z % 2) * 4 + (y % 2) * 2 + (x % 2);
    return (int'(vec_idx[f][p]) == pos) ? vec_val[f][p] : 16'h0000;
  endfunction

  task automatic send_filters(input int nf, input bit gaps);
    bit acc;
    int waited;
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < N_IN; k++) begin
        if (gaps) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 16'hDEAD;
          bus.in_idx   = 3'h5;
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = vec_val[f][k];
        bus.in_idx   = vec_idx[f][k];
        acc    = 1'b0;
        waited = 0;
        while (!acc && waited < 2000) begin
          @(negedge clk);
          acc = bus.in_ready;
          @(posedge clk); #1;
          waited++;
        end
        if (!acc) begin
          check("in_accept_timeout", 32'd0, 32'd1);
          bus.in_valid = 1'b0;
          return;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0BAD;
    bus.in_idx   = 3'h2;
  endtask

  task automatic collect(input int n, input int stall_at);
    int  cycles;
    bit  stalled;
    cycles  = 0;
    stalled = 1'b0;
    got_cnt = 0;
    bus.out_ready = 1'b1;
    while (got_cnt < n && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      if (bus.out_valid && bus.in_ready) overlap_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        got_data[got_cnt] = bus.out_data;
        got_last[got_cnt] = bus.out_last;
        got_cnt++;
      end
      @(posedge clk); #1;
      if (stall_at > 0 && got_cnt == stall_at && !stalled) begin
        stalled = 1'b1;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check($sformatf("stall_valid[%0d]", c), bus.out_valid, 1);
          check($sformatf("stall_data[%0d]", c), bus.out_data, exp_data[got_cnt]);
          check($sformatf("stall_last[%0d]", c), bus.out_last, exp_last[got_cnt]);
          if (bus.out_valid && bus.in_ready) overlap_cnt++;
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    end
    check("collect_count", got_cnt, n);
  endtask

  task automatic verify_stream(input string run, input int n);
    int lasts;
    lasts = 0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data[%0d]", run, i), got_data[i], exp_data[i]);
      check($sformatf("%s_last[%0d]", run, i), got_last[i], exp_last[i]);
      if (got_last[i]) lasts++;
    end
    check($sformatf("%s_last_count", run), lasts, n / N_OUT);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_idx    = '0;
    bus.out_ready = 1'b0;
    overlap_cnt   = 0;

    // Filter 0: values 1..8, argmax always at the window origin.
    // Filter 1: corner window (0,0,0) holds -5 at offset 7, the rest 9 at offset 0.
    // Filter 2: mixed signs and extremes with a different offset per window.
    for (int k = 0; k < N_IN; k++) begin
      vec_val[0][k] = 16'(k + 1);
      vec_idx[0][k] = 3'd0;
      vec_val[1][k] = (k == 0) ? 16'hFFFB : 16'd9;
      vec_idx[1][k] = (k == 0) ? 3'd7 : 3'd0;
      vec_idx[2][k] = 3'((k + 1) % 8);
    end
    vec_val[2][0] = 16'h012C;
    vec_val[2][1] = 16'hFFFF;
    vec_val[2][2] = 16'h0007;
    vec_val[2][3] = 16'h8000;
    vec_val[2][4] = 16'h7FFF;
    vec_val[2][5] = 16'h0000;
    vec_val[2][6] = 16'hFF38;
    vec_val[2][7] = 16'h0037;

    for (int f = 0; f < NUM_FILTERS; f++) begin
      for (int i = 0; i < N_OUT; i++) begin
        exp_data[f * N_OUT + i] = model(f, i);
        exp_last[f * N_OUT + i] = (i == N_OUT - 1);
      end
    end

    // Reset state.
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_done", bus.done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Run A: gap-free input, 10-cycle output stall in the middle of filter 1.
    fork
      send_filters(NUM_FILTERS, 1'b0);
      collect(N_TOT, N_OUT + 20);
    join
    check("A_f0_idx0", got_data[0], 16'd1);
    check("A_f0_idx1", got_data[1], 16'd0);
    check("A_f0_idx2", got_data[2], 16'd2);
    check("A_f0_idx10", got_data[10], 16'd4);
    check("A_f0_idx42", got_data[42], 16'd8);
    check("A_f0_idx43", got_data[43], 16'd0);
    check("A_f0_last62", got_last[62], 0);
    check("A_f0_last63", got_last[63], 1);
    check("A_f1_idx0", got_data[N_OUT + 0], 16'd0);
    check("A_f1_idx2", got_data[N_OUT + 2], 16'd9);
    check("A_f1_idx21", got_data[N_OUT + 21], 16'hFFFB);
    verify_stream("A", N_TOT);
    check("A_in_ready_during_emit", overlap_cnt, 0);

    // Completion: done rises the cycle after the final handshake and holds.
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      check($sformatf("done[%0d]", c), bus.done, 1);
      check($sformatf("done_in_ready[%0d]", c), bus.in_ready, 0);
      check($sformatf("done_out_valid[%0d]", c), bus.out_valid, 0);
    end
    @(posedge clk); #1;

    // Reset mid-EMIT: stop after output 30 of filter 1.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    fork
      send_filters(2, 1'b0);
      collect(N_OUT + 30, 0);
    join
    check("R_f1_out29", got_data[N_OUT + 29], exp_data[N_OUT + 29]);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("R_out_valid", bus.out_valid, 0);
    check("R_done", bus.done, 0);
    check("R_in_ready", bus.in_ready, 1);
    check("R_out_last", bus.out_last, 0);
    check("R_out_data", bus.out_data, 0);
    @(posedge clk); #1;

    // Run B: fresh 3-filter run with random input bubbles.
    overlap_cnt = 0;
    for (int i = 0; i < N_TOT; i++) begin
      got_data[i] = 16'h5A5A;
      got_last[i] = 1'b0;
    end
    fork
      send_filters(NUM_FILTERS, 1'b1);
      collect(N_TOT, 0);
    join
    verify_stream("B", N_TOT);
    check("B_in_ready_during_emit", overlap_cnt, 0);
    @(negedge clk);
    check("B_done", bus.done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
